// File: rtl/sample_compare_checker_pkg.sv
// Shared definitions for the sample compare checker.
// Holds the checker state encoding and a small helper that tells
// whether a state accepts sample traffic at all.
package sample_compare_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Only SKIP and CHECK consume expected/DUT samples; IDLE and DONE ignore them.
    function automatic logic in_stream_state(input state_e s);
        return (s == ST_SKIP) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/sample_compare_checker_fifo.sv
// cmp_sync_fifo: single-clock FIFO buffering expected samples.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear of all entries (wins over push/pop)
//   push, wdata  write request and data; accepted when not full, or when
//                full with a same-cycle pop
//   pop          read request; accepted only when not empty
//   rdata        head entry (combinational, valid when ~empty)
//   full, empty  occupancy flags
module cmp_sync_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         pop_ok_s;
    logic         push_ok_s;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];
    assign pop_ok_s  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointer and storage next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sample_compare_checker.sv
// sample_compare_checker: buffers expected samples and compares them in
// order against DUT samples within +/-TOLERANCE, after discarding a
// programmable number of leading samples.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 restart pulse: clears results, flushes buffer
//   skip_num, num_samples leading samples to discard / compares before done
//                         (0 = unlimited); both sampled on start
//   exp_valid, exp_data   expected sample stream
//   dut_valid, dut_data   DUT sample stream
//   mismatch              one-cycle pulse per failed compare
//   err_cnt, match_cnt    saturating result counters
//   first_err_idx         0-based index of the first failed compare
//   ovf, unf              sticky buffer overflow / underflow flags
//   done, pass            run finished / finished cleanly
module sample_compare_checker
    import sample_compare_checker_pkg::*;
#(
    parameter int SIG_WIDTH  = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int TOLERANCE  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] skip_num,
    input  logic [CNT_WIDTH-1:0] num_samples,
    input  logic                 exp_valid,
    input  logic [SIG_WIDTH-1:0] exp_data,
    input  logic                 dut_valid,
    input  logic [SIG_WIDTH-1:0] dut_data,
    output logic                 mismatch,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] match_cnt,
    output logic [CNT_WIDTH-1:0] first_err_idx,
    output logic                 ovf,
    output logic                 unf,
    output logic                 done,
    output logic                 pass
);

    localparam logic [SIG_WIDTH:0]   TOL_W    = (SIG_WIDTH+1)'(TOLERANCE);
    localparam logic [SIG_WIDTH:0]   DIFF_ONE = (SIG_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] skip_cnt_q, skip_cnt_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_WIDTH-1:0] first_err_idx_q, first_err_idx_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 mismatch_q, mismatch_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic                 push_s, pop_s;
    logic                 fifo_full_s, fifo_empty_s;
    logic [SIG_WIDTH-1:0] fifo_rdata_s;
    logic [SIG_WIDTH:0]   diff_s, abs_s;
    logic                 cmp_ok_s;

    // Samples arriving together with start belong to no run; start flushes.
    assign push_s = !start && exp_valid && in_stream_state(state_q);
    assign pop_s  = !start && dut_valid && !fifo_empty_s && in_stream_state(state_q);

    cmp_sync_fifo #(
        .W     (SIG_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (exp_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sign-extend one bit so dut-exp never overflows, then take the magnitude.
    assign diff_s = {dut_data[SIG_WIDTH-1], dut_data} -
                    {fifo_rdata_s[SIG_WIDTH-1], fifo_rdata_s};
    assign abs_s  = diff_s[SIG_WIDTH] ? (~diff_s + DIFF_ONE) : diff_s;
    // An empty buffer means there is nothing to compare against: always an error.
    assign cmp_ok_s = !fifo_empty_s && (abs_s <= TOL_W);

    // FSM next-state, counters and result flags.
    always_comb begin
        state_d         = state_q;
        skip_cnt_d      = skip_cnt_q;
        num_d           = num_q;
        idx_d           = idx_q;
        err_cnt_d       = err_cnt_q;
        match_cnt_d     = match_cnt_q;
        first_err_idx_d = first_err_idx_q;
        ovf_d           = ovf_q;
        unf_d           = unf_q;
        mismatch_d      = 1'b0;
        if (start) begin
            state_d         = (skip_num == CNT_ZERO) ? ST_CHECK : ST_SKIP;
            skip_cnt_d      = skip_num;
            num_d           = num_samples;
            idx_d           = CNT_ZERO;
            err_cnt_d       = CNT_ZERO;
            match_cnt_d     = CNT_ZERO;
            first_err_idx_d = CNT_ZERO;
            ovf_d           = 1'b0;
            unf_d           = 1'b0;
        end else begin
            if (push_s && fifo_full_s && !pop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SKIP: begin
                    if (dut_valid) begin
                        skip_cnt_d = skip_cnt_q - CNT_ONE;
                        if (skip_cnt_q == CNT_ONE) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_SKIP;
                        end
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_CHECK: begin
                    if (dut_valid) begin
                        // The index wraps rather than saturating; DONE needs an exact hit.
                        idx_d = idx_q + CNT_ONE;
                        if (cmp_ok_s) begin
                            if (match_cnt_q != CNT_MAX) begin
                                match_cnt_d = match_cnt_q + CNT_ONE;
                            end else begin
                                match_cnt_d = match_cnt_q;
                            end
                        end else begin
                            mismatch_d = 1'b1;
                            if (err_cnt_q != CNT_MAX) begin
                                err_cnt_d = err_cnt_q + CNT_ONE;
                            end else begin
                                err_cnt_d = err_cnt_q;
                            end
                            if (err_cnt_q == CNT_ZERO) begin
                                first_err_idx_d = idx_q;
                            end else begin
                                first_err_idx_d = first_err_idx_q;
                            end
                        end
                        if (fifo_empty_s) begin
                            unf_d = 1'b1;
                        end else begin
                            unf_d = unf_q;
                        end
                        if ((num_q != CNT_ZERO) && (idx_d == num_q)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_cnt_d == CNT_ZERO) && !ovf_d && !unf_d;
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            skip_cnt_q      <= CNT_ZERO;
            num_q           <= CNT_ZERO;
            idx_q           <= CNT_ZERO;
            err_cnt_q       <= CNT_ZERO;
            match_cnt_q     <= CNT_ZERO;
            first_err_idx_q <= CNT_ZERO;
            ovf_q           <= 1'b0;
            unf_q           <= 1'b0;
            mismatch_q      <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            skip_cnt_q      <= skip_cnt_d;
            num_q           <= num_d;
            idx_q           <= idx_d;
            err_cnt_q       <= err_cnt_d;
            match_cnt_q     <= match_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            ovf_q           <= ovf_d;
            unf_q           <= unf_d;
            mismatch_q      <= mismatch_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
        end
    end

    assign mismatch      = mismatch_q;
    assign err_cnt       = err_cnt_q;
    assign match_cnt     = match_cnt_q;
    assign first_err_idx = first_err_idx_q;
    assign ovf           = ovf_q;
    assign unf           = unf_q;
    assign done          = done_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_sample_compare_checker.sv
// Directed bench: two checker instances (TOLERANCE 0 and 3) see identical
// stimulus; results are compared against hand-computed expectations.
module tb_sample_compare_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] skip_num;
    logic [15:0] num_samples;
    logic        exp_valid;
    logic [9:0]  exp_data;
    logic        dut_valid;
    logic [9:0]  dut_data;

    logic        mm0, ovf0, unf0, done0, pass0;
    logic [15:0] err0, match0, first0;
    logic        mm3, ovf3, unf3, done3, pass3;
    logic [15:0] err3, match3, first3;

    logic [9:0]  exp_arr [128];
    logic [9:0]  dut_arr [128];

    int n_total;
    int n_bad;
    int mm_cnt0;
    int mm_cnt3;
    int mm_base0;
    int mm_base3;

    sample_compare_checker #(
        .SIG_WIDTH(10), .FIFO_DEPTH(16), .TOLERANCE(0), .CNT_WIDTH(16)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .skip_num(skip_num),
        .num_samples(num_samples), .exp_valid(exp_valid), .exp_data(exp_data),
        .dut_valid(dut_valid), .dut_data(dut_data), .mismatch(mm0),
        .err_cnt(err0), .match_cnt(match0), .first_err_idx(first0),
        .ovf(ovf0), .unf(unf0), .done(done0), .pass(pass0)
    );

    sample_compare_checker #(
        .SIG_WIDTH(10), .FIFO_DEPTH(16), .TOLERANCE(3), .CNT_WIDTH(16)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .skip_num(skip_num),
        .num_samples(num_samples), .exp_valid(exp_valid), .exp_data(exp_data),
        .dut_valid(dut_valid), .dut_data(dut_data), .mismatch(mm3),
        .err_cnt(err3), .match_cnt(match3), .first_err_idx(first3),
        .ovf(ovf3), .unf(unf3), .done(done3), .pass(pass3)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mismatch pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (mm0) mm_cnt0 = mm_cnt0 + 1;
        if (mm3) mm_cnt3 = mm_cnt3 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total = n_total + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_dut(input string tag, input int sel, input int e_err, input int e_match,
                             input int e_first, input int e_done, input int e_pass,
                             input int e_ovf, input int e_unf);
        logic [15:0] g_err, g_match, g_first;
        logic        g_done, g_pass, g_ovf, g_unf;
        if (sel == 0) begin
            g_err = err0; g_match = match0; g_first = first0;
            g_done = done0; g_pass = pass0; g_ovf = ovf0; g_unf = unf0;
        end else begin
            g_err = err3; g_match = match3; g_first = first3;
            g_done = done3; g_pass = pass3; g_ovf = ovf3; g_unf = unf3;
        end
        check_val($sformatf("%s.t%0d.err", tag, sel), 32'(g_err), e_err);
        check_val($sformatf("%s.t%0d.match", tag, sel), 32'(g_match), e_match);
        check_val($sformatf("%s.t%0d.first", tag, sel), 32'(g_first), e_first);
        check_val($sformatf("%s.t%0d.done", tag, sel), 32'(g_done), e_done);
        check_val($sformatf("%s.t%0d.pass", tag, sel), 32'(g_pass), e_pass);
        check_val($sformatf("%s.t%0d.ovf", tag, sel), 32'(g_ovf), e_ovf);
        check_val($sformatf("%s.t%0d.unf", tag, sel), 32'(g_unf), e_unf);
    endtask

    task automatic do_start(input int skip, input int num);
        @(posedge clk); #1;
        start = 1'b1; skip_num = 16'(skip); num_samples = 16'(num);
        @(posedge clk); #1;
        start = 1'b0;
        mm_base0 = mm_cnt0;
        mm_base3 = mm_cnt3;
    endtask

    // Expected samples on cycles [0, n_exp); DUT samples on [lag, lag+n_dut).
    task automatic run(input int n_exp, input int n_dut, input int lag);
        int total;
        total = (n_exp > lag + n_dut) ? n_exp : lag + n_dut;
        for (int c = 0; c < total; c++) begin
            @(posedge clk); #1;
            exp_valid = (c < n_exp);
            exp_data  = (c < n_exp) ? exp_arr[c] : 10'd0;
            dut_valid = (c >= lag) && (c < lag + n_dut);
            dut_data  = ((c >= lag) && (c < lag + n_dut)) ? dut_arr[c - lag] : 10'd0;
        end
        @(posedge clk); #1;
        exp_valid = 1'b0;
        dut_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_equal(input int n);
        for (int i = 0; i < n; i++) begin
            exp_arr[i] = 10'(((i * 7) % 200) - 100);
            dut_arr[i] = exp_arr[i];
        end
    endtask

    initial begin
        n_total = 0; n_bad = 0; mm_cnt0 = 0; mm_cnt3 = 0; mm_base0 = 0; mm_base3 = 0;
        rst_n = 1'b0; start = 1'b0; skip_num = 16'd0; num_samples = 16'd0;
        exp_valid = 1'b0; exp_data = 10'd0; dut_valid = 1'b0; dut_data = 10'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_dut("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("reset.mismatch", 32'(mm0), 0);
        rst_n = 1'b1;

        // 1: identical streams, DUT lags 5 cycles.
        fill_equal(100);
        do_start(0, 100);
        run(100, 100, 5);
        check_dut("s1", 0, 0, 100, 0, 1, 1, 0, 0);
        check_dut("s1", 3, 0, 100, 0, 1, 1, 0, 0);

        // 2: sample 37 off by +3.
        fill_equal(100);
        dut_arr[37] = exp_arr[37] + 10'd3;
        do_start(0, 100);
        run(100, 100, 5);
        check_dut("s2", 0, 1, 99, 37, 1, 0, 0, 0);
        check_dut("s2", 3, 0, 100, 0, 1, 1, 0, 0);
        check_val("s2.t0.pulses", 32'(mm_cnt0 - mm_base0), 1);
        check_val("s2.t3.pulses", 32'(mm_cnt3 - mm_base3), 0);
        // DONE ignores further traffic.
        for (int i = 0; i < 5; i++) dut_arr[i] = 10'd300;
        run(5, 5, 1);
        check_dut("s2hold", 0, 1, 99, 37, 1, 0, 0, 0);

        // 3: full-scale extremes and tolerance boundary.
        exp_arr[0] = 10'd10;            dut_arr[0] = 10'd10;
        exp_arr[1] = 10'd511;           dut_arr[1] = 10'h200;
        exp_arr[2] = 10'h200;           dut_arr[2] = 10'd511;
        exp_arr[3] = 10'd100;           dut_arr[3] = 10'd104;
        exp_arr[4] = 10'd100;           dut_arr[4] = 10'd97;
        do_start(0, 5);
        run(5, 5, 1);
        check_dut("s3", 0, 4, 1, 1, 1, 0, 0, 0);
        check_dut("s3", 3, 3, 2, 1, 1, 0, 0, 0);

        // 4: skip 4 leading junk samples on both streams.
        fill_equal(54);
        for (int i = 0; i < 4; i++) begin
            exp_arr[i] = 10'(300 + i);
            dut_arr[i] = 10'(-300 - i);
        end
        do_start(4, 50);
        run(54, 54, 5);
        check_dut("s4", 0, 0, 50, 0, 1, 1, 0, 0);

        // 5: 17 pushes into a 16-deep buffer, then drain past empty.
        fill_equal(17);
        do_start(0, 17);
        run(17, 17, 17);
        check_dut("s5", 0, 1, 16, 16, 1, 0, 1, 1);
        check_dut("s5", 3, 1, 16, 16, 1, 0, 1, 1);

        // 6: asynchronous reset mid-run, then a clean rerun.
        fill_equal(100);
        do_start(0, 100);
        run(30, 30, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_dut("s6rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(0, 100);
        run(100, 100, 5);
        check_dut("s6", 0, 0, 100, 0, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
